// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate-decode stage: fetch-side offer plus
// decoded-result delivery toward register read / execute.
interface imm_decode_stage_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_type, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32/RV64 immediate decoder: classifies each instruction by opcode,
// extends its immediate to XLEN, and holds results in a two-entry skid buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no entry held; out_valid=0, in_ready=1
// ST_ONE   | main entry held; out_valid=1, in_ready=1
// ST_TWO   | main and skid held; out_valid=1, in_ready=0
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    imm_decode_stage_if.slave  bus
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_Z   = 3'd6;
    localparam logic [2:0] T_ILL = 3'd7;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_FMADD     = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB     = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t          state;
    state_t          state_nxt;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          dec;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_csr;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_sh32;
    logic            accept;
    logic            drain;
    logic            ld_main_in;
    logic            ld_main_skid;
    logic            ld_skid_in;

    assign instr    = bus.in_instr;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

    // Size casts of signed operands sign-extend (or truncate) to XLEN.
    assign imm_i    = XLEN'($signed(instr[31:20]));
    assign imm_s    = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_csr  = XLEN'(instr[31:20]);
    assign imm_z    = XLEN'(instr[19:15]);
    assign imm_sh   = RV64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign imm_sh32 = XLEN'(instr[24:20]);

    always_comb begin
        dec.instr = instr;
        dec.pc    = bus.in_pc;
        dec.typ   = T_ILL;
        dec.imm   = '0;
        case (opcode)
            OPC_LOAD, OPC_LOAD_FP, OPC_MISC_MEM, OPC_JALR: begin
                dec.typ = T_I;
                dec.imm = imm_i;
            end
            OPC_OP_IMM: begin
                dec.typ = T_I;
                dec.imm = is_shift ? imm_sh : imm_i;
            end
            OPC_OP_IMM_32: begin
                if (RV64) begin
                    dec.typ = T_I;
                    dec.imm = is_shift ? imm_sh32 : imm_i;
                end
            end
            OPC_STORE, OPC_STORE_FP: begin
                dec.typ = T_S;
                dec.imm = imm_s;
            end
            OPC_BRANCH: begin
                dec.typ = T_B;
                dec.imm = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.typ = T_U;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.typ = T_J;
                dec.imm = imm_j;
            end
            OPC_OP, OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                dec.typ = T_R;
            end
            OPC_OP_32: begin
                if (RV64) dec.typ = T_R;
            end
            OPC_SYSTEM: begin
                case (funct3)
                    3'd0: begin
                        dec.typ = T_I;
                        dec.imm = imm_i;
                    end
                    3'd1, 3'd2, 3'd3: begin
                        dec.typ = T_I;
                        dec.imm = imm_csr;
                    end
                    3'd5, 3'd6, 3'd7: begin
                        dec.typ = T_Z;
                        dec.imm = imm_z;
                    end
                    default: begin
                        dec.typ = T_ILL;
                        dec.imm = '0;
                    end
                endcase
            end
            default: begin
                dec.typ = T_ILL;
                dec.imm = '0;
            end
        endcase
    end

    // State bits double as the registered out_valid / !in_ready flags.
    assign accept = bus.in_valid && !state[1];
    assign drain  = state[0] && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (bus.flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        ld_main_in = 1'b1;
                        state_nxt  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        ld_skid_in = 1'b1;
                        state_nxt  = ST_TWO;
                    end else if (drain) begin
                        state_nxt  = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        ld_main_skid = 1'b1;
                        state_nxt    = ST_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_q <= dec;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid_in) begin
                skid_q <= dec;
            end
        end
    end

    assign bus.in_ready    = !state[1];
    assign bus.out_valid   = state[0];
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_type    = main_q.typ;
    assign bus.out_illegal = (main_q.typ == T_ILL);

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: one RV32 and one RV64 instance, each
// checked against an arithmetic reference decoder.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic [6:0] opc_tab [20] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h67, 7'h23, 7'h27, 7'h63, 7'h37, 7'h17,
                                 7'h6F, 7'h33, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h1B, 7'h3B, 7'h73};

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_decode_stage #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    always #5 clk = ~clk;

    function automatic logic [63:0] sx(logic [63:0] v, int bits);
        if (v >= (64'd1 << (bits - 1))) return v - (64'd1 << bits);
        return v;
    endfunction

    // Reference decoder: immediates built as weighted sums, then sign-folded.
    function automatic exp_t model(logic [31:0] w, logic [63:0] pc, bit rv64);
        exp_t e;
        logic [63:0] iv, sv, bv, uv, jv;
        int opc, f3;
        bit sh;
        opc = int'(w[6:0]);
        f3  = int'(w[14:12]);
        sh  = (f3 == 1) || (f3 == 5);
        iv  = sx(64'(w[31:20]), 12);
        sv  = sx(64'(w[31:25]) * 32 + 64'(w[11:7]), 12);
        bv  = sx(64'(w[31]) * 4096 + 64'(w[7]) * 2048 + 64'(w[30:25]) * 32 + 64'(w[11:8]) * 2, 13);
        uv  = sx(64'(w[31:12]) * 4096, 32);
        jv  = sx(64'(w[31]) * 1048576 + 64'(w[19:12]) * 4096 + 64'(w[20]) * 2048 + 64'(w[30:21]) * 2, 21);
        e.instr = w;
        e.pc    = rv64 ? pc : (pc & 64'hFFFF_FFFF);
        e.typ   = 3'd7;
        e.imm   = 64'd0;
        if (opc inside {'h03, 'h07, 'h0F, 'h67}) begin
            e.typ = 3'd1; e.imm = iv;
        end else if (opc == 'h13) begin
            e.typ = 3'd1;
            e.imm = !sh ? iv : (rv64 ? 64'(w[25:20]) : 64'(w[24:20]));
        end else if (opc == 'h1B && rv64) begin
            e.typ = 3'd1; e.imm = sh ? 64'(w[24:20]) : iv;
        end else if (opc inside {'h23, 'h27}) begin
            e.typ = 3'd2; e.imm = sv;
        end else if (opc == 'h63) begin
            e.typ = 3'd3; e.imm = bv;
        end else if (opc inside {'h37, 'h17}) begin
            e.typ = 3'd4; e.imm = uv;
        end else if (opc == 'h6F) begin
            e.typ = 3'd5; e.imm = jv;
        end else if (opc inside {'h33, 'h53, 'h43, 'h47, 'h4B, 'h4F} || (opc == 'h3B && rv64)) begin
            e.typ = 3'd0;
        end else if (opc == 'h73) begin
            if (f3 == 0) begin
                e.typ = 3'd1; e.imm = iv;
            end else if (f3 >= 1 && f3 <= 3) begin
                e.typ = 3'd1; e.imm = 64'(w[31:20]);
            end else if (f3 >= 5) begin
                e.typ = 3'd6; e.imm = 64'(w[19:15]);
            end
        end
        if (!rv64) e.imm = e.imm & 64'hFFFF_FFFF;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, logic [31:0] ai, logic [63:0] ap, logic [63:0] am,
                             logic [2:0] at, logic al, exp_t e);
        n_vec++;
        if (ai !== e.instr || ap !== e.pc || am !== e.imm || at !== e.typ || al !== (e.typ == 3'd7)) begin
            n_bad++;
            $display("FAIL %s entry: got instr %h pc %h imm %h type %0d ill %0d, expected instr %h pc %h imm %h type %0d",
                     tag, ai, ap, am, at, al, e.instr, e.pc, e.imm, e.typ);
        end
    endtask

    // Stimulus side: every accepted instruction becomes an expected entry.
    always @(negedge clk) begin
        if (rst_n && !b32.flush && b32.in_valid && b32.in_ready)
            q32.push_back(model(b32.in_instr, {32'd0, b32.in_pc}, 1'b0));
        if (rst_n && !b64.flush && b64.in_valid && b64.in_ready)
            q64.push_back(model(b64.in_instr, b64.in_pc, 1'b1));
    end

    // Monitors: a presented entry must match the queue head every cycle it is shown.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
        end else begin
            if (b32.out_valid) begin
                if (q32.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL u32 spurious out_valid: got instr %h, expected no entry", b32.out_instr);
                end else begin
                    check_out("u32", b32.out_instr, {32'd0, b32.out_pc}, {32'd0, b32.out_imm},
                              b32.out_type, b32.out_illegal, q32[0]);
                    if (b32.out_ready) void'(q32.pop_front());
                end
            end
            if (b32.flush) q32.delete();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q64.delete();
        end else begin
            if (b64.out_valid) begin
                if (q64.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL u64 spurious out_valid: got instr %h, expected no entry", b64.out_instr);
                end else begin
                    check_out("u64", b64.out_instr, b64.out_pc, b64.out_imm,
                              b64.out_type, b64.out_illegal, q64[0]);
                    if (b64.out_ready) void'(q64.pop_front());
                end
            end
            if (b64.flush) q64.delete();
        end
    end

    // Offers one instruction and returns 1ns after the edge that accepted it.
    task automatic drive(bit d64, logic [31:0] w);
        logic [63:0] pc;
        bit ok;
        ok = 1'b0;
        pc = {$urandom, $urandom};
        if (d64) begin
            b64.in_valid = 1'b1; b64.in_instr = w; b64.in_pc = pc;
        end else begin
            b32.in_valid = 1'b1; b32.in_instr = w; b32.in_pc = pc[31:0];
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = d64 ? b64.in_ready : b32.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL drive timeout: got no accept of %h, expected accept within 50 cycles", w);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = opc_tab[$urandom_range(0, 19)];
        return w;
    endfunction

    initial begin
        b32.in_valid = 0; b32.in_instr = 0; b32.in_pc = 0; b32.flush = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.in_instr = 0; b64.in_pc = 0; b64.flush = 0; b64.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst32_valid", 64'(b32.out_valid), 64'd0);
        chk("rst32_ready", 64'(b32.in_ready), 64'd1);
        chk("rst32_fields", {b32.out_instr, b32.out_imm}, 64'd0);
        chk("rst32_pc_type", {b32.out_pc, 28'd0, b32.out_illegal, b32.out_type}, 64'd0);
        chk("rst64_valid", 64'(b64.out_valid), 64'd0);
        chk("rst64_imm", b64.out_imm, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // negative I immediate, one-cycle latency
        drive(0, 32'hFFF00093);
        b32.in_valid = 0;
        chk("addi_valid", 64'(b32.out_valid), 64'd1);
        chk("addi_imm", 64'(b32.out_imm), 64'hFFFF_FFFF);
        chk("addi_type", 64'(b32.out_type), 64'd1);
        chk("addi_ill", 64'(b32.out_illegal), 64'd0);
        @(posedge clk); #1;

        // streaming B then Z on consecutive cycles
        drive(0, 32'hFE000EE3);
        chk("beq_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
        chk("beq_type", 64'(b32.out_type), 64'd3);
        drive(0, 32'h3002D073);
        b32.in_valid = 0;
        chk("csrrwi_imm", 64'(b32.out_imm), 64'd5);
        chk("csrrwi_type", 64'(b32.out_type), 64'd6);
        @(posedge clk); #1;

        // RV64 sign extension and 6-bit shamt; OP-IMM-32 legal on RV64
        drive(1, 32'h800002B7);
        chk("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_type", 64'(b64.out_type), 64'd4);
        drive(1, 32'h03F09093);
        chk("slli64_imm", b64.out_imm, 64'h3F);
        drive(1, 32'h0000001B);
        b64.in_valid = 0;
        chk("opimm32_rv64_type", 64'(b64.out_type), 64'd1);
        @(posedge clk); #1;

        // illegal encodings are delivered
        drive(0, 32'h00000000);
        chk("zero_ill", 64'(b32.out_illegal), 64'd1);
        drive(0, 32'h0000001B);
        b32.in_valid = 0;
        chk("opimm32_rv32_type", 64'(b32.out_type), 64'd7);
        chk("opimm32_rv32_imm", 64'(b32.out_imm), 64'd0);
        @(posedge clk); #1;

        // back-pressure: stall 3 cycles after first accept
        b32.out_ready = 0;
        drive(0, 32'h00500113);
        drive(0, 32'h00A12023);
        chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        b32.out_ready = 1;
        drive(0, 32'h0040006F);
        drive(0, 32'h12345537);
        b32.in_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", 64'(q32.size()), 64'd0);

        // flush with both entries full, and with a handshake in the flush cycle
        b32.out_ready = 0;
        drive(0, 32'h00100093);
        drive(0, 32'h00200113);
        b32.in_instr = 32'h00300193; b32.flush = 1;
        @(posedge clk); #1;
        b32.flush = 0; b32.in_valid = 0;
        chk("flush_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_ready", 64'(b32.in_ready), 64'd1);
        drive(0, 32'h00400213);
        b32.in_instr = 32'h00500293; b32.flush = 1; b32.out_ready = 1;
        @(posedge clk); #1;
        b32.flush = 0; b32.in_valid = 0;
        chk("flush2_valid", 64'(b32.out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset mid-stream
        b32.out_ready = 0;
        drive(0, 32'hFFF00093);
        drive(0, 32'hFE000EE3);
        b32.in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(b32.out_valid), 64'd0);
        chk("arst_ready", 64'(b32.in_ready), 64'd1);
        chk("arst_fields", {b32.out_instr, b32.out_imm}, 64'd0);
        chk("arst_pc_type", {b32.out_pc, 28'd0, b32.out_illegal, b32.out_type}, 64'd0);
        q32.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized traffic on both widths
        for (int c = 0; c < 1500; c++) begin
            b32.in_valid  = ($urandom_range(0, 3) != 0);
            b32.in_instr  = rand_instr();
            b32.in_pc     = $urandom;
            b32.out_ready = ($urandom_range(0, 3) != 0);
            b32.flush     = ($urandom_range(0, 59) == 0);
            b64.in_valid  = ($urandom_range(0, 3) != 0);
            b64.in_instr  = rand_instr();
            b64.in_pc     = {$urandom, $urandom};
            b64.out_ready = ($urandom_range(0, 2) != 0);
            b64.flush     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        b32.in_valid = 0; b32.flush = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.flush = 0; b64.out_ready = 1;
        for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
        #1;
        chk("end_q32_empty", 64'(q32.size()), 64'd0);
        chk("end_q64_empty", 64'(q64.size()), 64'd0);
        chk("end_valid", {62'd0, b32.out_valid, b64.out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode stage for the RV32/RV64 front end with F/D support. It accepts raw 32-bit instructions over a valid/ready handshake and classifies each by opcode. It emits the XLEN-wide sign- or zero-extended immediate with the instruction type, and buffers results in a two-entry skid buffer so back-pressure never drops or duplicates an instruction. It sits between fetch and the register-read/execute stage and replaces the purely combinational extender, which needed the instruction type supplied externally.

## Interface
- XLEN, default 32: datapath width, legal values 32 or 64.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept. Driven from a register.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC tag, carried unchanged.
- flush  in  1  synchronous discard of all held entries.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction word, passed through.
- out_pc  out  XLEN  PC tag.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  type code: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7.
- out_illegal  out  1  set when out_type is ILL.

## Operation
- Decode is combinational on in_instr, before the register. The main and skid entries store results that are already decoded.
- Opcode map, instr[6:0], where instr[1:0] must be 2'b11 or the type is ILL:
  - I: LOAD 0000011, LOAD-FP 0000111, MISC-MEM 0001111, OP-IMM 0010011, JALR 1100111.
  - S: STORE 0100011, STORE-FP 0100111.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - R: OP 0110011, OP-FP 1010011, and FMADD/FMSUB/FNMSUB/FNMADD (1000011/1000111/1001011/1001111).
  - XLEN=64 only: OP-IMM-32 0011011 is I, OP-32 0111011 is R. With XLEN=32 both are ILL.
  - SYSTEM 1110011, by funct3:
    - 0: I, sign-extended.
    - 1, 2, 3: I, with instr[31:20] zero-extended (CSR address).
    - 5, 6, 7: Z.
    - 4: ILL.
- Immediates. All sign-extend from instr[31] to XLEN unless stated:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended for XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: instr[19:15] zero-extended.
  - R and ILL: 0.
- OP-IMM shifts (funct3 1 or 5): the immediate is the zero-extended shamt. This is instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64. OP-IMM-32 shifts use instr[24:20].
- ILL entries are passed downstream, never dropped, so the trap logic sees them.
- Skid buffer:
  - in_ready = !skid_valid.
  - Accept on in_valid && in_ready.
  - If the main entry is empty, or is draining this cycle (out_valid && out_ready), the accepted entry goes to main.
  - Otherwise it goes to skid.
  - When main drains and skid is full, skid moves into main.
  - Order is strictly FIFO.

## Timing
- Latency is 1 cycle: an entry accepted at edge N has out_valid=1 after edge N.
- Throughput is 1 per cycle with out_ready held at 1.
- There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- While out_valid && !out_ready, all out_* hold stable.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, both entries empty, in_ready=1.
  - out_instr, out_pc and out_imm are 0; out_type=0; out_illegal=0.
  - Reset asserted mid-stream discards held entries immediately.
- Flush:
  - At the next edge both entries are emptied, out_valid=0 and in_ready=1.
  - A handshake occurring in the flush cycle is discarded.
  - A downstream handshake in the flush cycle counts as consumed.
- Full buffer (skid_valid=1): in_ready=0. A simultaneous drain frees skid at that edge, and in_ready=1 in the following cycle.

## Test plan
- **Negative I immediate.** XLEN=32, 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, type I (1), out_imm 0xFFFFFFFF, out_illegal=0.
- **B-type and streaming.** XLEN=32, 0xFE000EE3 (beq -4), then 0x3002D073 (csrrwi mstatus,5) back-to-back → out_imm 0xFFFFFFFC with type B (3), then out_imm 0x00000005 with type Z (6), on consecutive cycles.
- **RV64 extension.** XLEN=64, 0x800002B7 (lui x5,0x80000) → out_imm 0xFFFFFFFF80000000, type U. Also 0x03F09093 (slli x1,x1,63) → out_imm 0x3F.
- **Back-pressure.** Offer 4 distinct instructions continuously, with out_ready=0 for 3 cycles after the first accept → in_ready falls after the second accept. All 4 emerge in order with no duplicates, and out_* are stable while stalled.
- **Illegal encodings.** 0x00000000, and with XLEN=32 the word 0x0000001B → out_type 7, out_illegal=1, out_imm 0, and the entry is still delivered.
- **Flush and reset.** With both entries full, assert flush for one cycle → out_valid=0 and in_ready=1 next cycle, and an input offered in the flush cycle never appears. Then fill again and pulse rst_n low mid-cycle → out_valid drops immediately and all outputs read 0.
